// File: rtl/fifo_rd_pkg.sv
// Shared types and helpers for the FIFO read-side packer.
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        FL_WAIT = 2'd1,
        FL_EMIT = 2'd2
    } state_t;

    localparam int MAX_PACK = 32;

    // Bit i set when lane i holds data, for a fill count of n lanes.
    function automatic logic [MAX_PACK-1:0] keep_mask(input int n);
        logic [MAX_PACK-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_PACK; i++) begin
            if (i < n) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/fifo_rd_packer.sv
// Drains the async FIFO read port and packs PACK entries per output word,
// with credit-based popping and a flush that emits a lane-masked partial word.
module fifo_rd_packer
    import fifo_rd_pkg::*;
#(
    parameter  int READ_WIDTH = 4,
    parameter  int PACK       = 2,
    parameter  int CNT_WIDTH  = 16,
    localparam int OUT_WIDTH  = READ_WIDTH * PACK
) (
    input  logic                  rd_clk,
    input  logic                  rst_n,
    input  logic                  empty,
    input  logic                  valid,
    input  logic [READ_WIDTH-1:0] dout,
    output logic                  rd_en,
    input  logic                  flush,
    output logic [OUT_WIDTH-1:0]  m_data,
    output logic [PACK-1:0]       m_keep,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  word_cnt,
    output logic                  busy
);

    localparam int LANE_W = $clog2(PACK + 1);
    localparam int OCC_W  = $clog2(3 * PACK + 2);

    state_t                state, state_nx;
    logic [LANE_W-1:0]     lane;
    logic                  infl;
    logic [OUT_WIDTH-1:0]  acc;

    logic [OCC_W-1:0]      occ;
    logic                  out_free;
    logic                  capture;
    logic                  complete;
    logic                  held;
    logic                  load_part;
    logic [OUT_WIDTH-1:0]  direct_word;
    logic [OUT_WIDTH-1:0]  part_word;
    logic [PACK-1:0]       part_keep;

    // Credit: accumulator lanes + in-flight entry + output word, capped at 2*PACK.
    assign occ      = OCC_W'(lane) + OCC_W'(infl) + (m_valid ? OCC_W'(PACK) : '0);
    assign rd_en    = !empty && (occ < OCC_W'(2 * PACK)) && (state == RUN);
    assign out_free = !m_valid || m_ready;
    // Gating on infl drops a stale valid left over from before a reset.
    assign capture  = valid && infl;
    assign complete = capture && (lane == LANE_W'(PACK - 1));
    assign held     = (lane == LANE_W'(PACK));
    assign load_part = (state == FL_EMIT) && (lane != '0) && !held && out_free;
    assign busy     = (lane != '0) || infl || (state != RUN);

    always_comb begin
        direct_word = acc;
        direct_word[(PACK-1)*READ_WIDTH +: READ_WIDTH] = dout;
        part_keep = PACK'(keep_mask(int'(lane)));
        part_word = '0;
        for (int i = 0; i < PACK; i++) begin
            if (part_keep[i]) part_word[i*READ_WIDTH +: READ_WIDTH] = acc[i*READ_WIDTH +: READ_WIDTH];
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            RUN:     if (flush) state_nx = FL_WAIT;
            FL_WAIT: if (!infl) state_nx = (lane == '0) ? RUN : FL_EMIT;
            // A held full word may have transferred on the way in; nothing left then.
            FL_EMIT: if ((lane == '0) || out_free) state_nx = RUN;
            default: state_nx = RUN;
        endcase
    end

    always_ff @(posedge rd_clk) begin
        if (!rst_n) begin
            state    <= RUN;
            lane     <= '0;
            infl     <= 1'b0;
            acc      <= '0;
            m_data   <= '0;
            m_keep   <= '0;
            m_valid  <= 1'b0;
            word_cnt <= '0;
        end else begin
            state <= state_nx;

            if (rd_en)      infl <= 1'b1;
            else if (valid) infl <= 1'b0;

            if (m_valid && m_ready) begin
                m_valid  <= 1'b0;
                word_cnt <= word_cnt + 1'b1;
            end

            // Accumulator -> output register transfer
            if (capture) begin
                if (complete && out_free) begin
                    m_data  <= direct_word;
                    m_keep  <= '1;
                    m_valid <= 1'b1;
                    lane    <= '0;
                end else begin
                    acc[int'(lane)*READ_WIDTH +: READ_WIDTH] <= dout;
                    lane <= lane + 1'b1;
                end
            end else if (held && out_free) begin
                m_data  <= acc;
                m_keep  <= '1;
                m_valid <= 1'b1;
                lane    <= '0;
            end else if (load_part) begin
                m_data  <= part_word;
                m_keep  <= part_keep;
                m_valid <= 1'b1;
                lane    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer with a queue-based FIFO and packing model.
module tb_fifo_rd_packer;

    localparam int RW   = 4;
    localparam int PACK = 2;
    localparam int CW   = 4;
    localparam int OW   = RW * PACK;

    typedef struct packed {
        logic [OW-1:0]   data;
        logic [PACK-1:0] keep;
    } word_t;

    logic            rd_clk = 1'b0;
    logic            rst_n  = 1'b0;
    logic            empty  = 1'b1;
    logic            valid  = 1'b0;
    logic [RW-1:0]   dout   = '0;
    logic            rd_en;
    logic            flush  = 1'b0;
    logic [OW-1:0]   m_data;
    logic [PACK-1:0] m_keep;
    logic            m_valid;
    logic            m_ready = 1'b1;
    logic [CW-1:0]   word_cnt;
    logic            busy;

    fifo_rd_packer #(.READ_WIDTH(RW), .PACK(PACK), .CNT_WIDTH(CW)) dut (
        .rd_clk(rd_clk), .rst_n(rst_n), .empty(empty), .valid(valid), .dout(dout),
        .rd_en(rd_en), .flush(flush), .m_data(m_data), .m_keep(m_keep),
        .m_valid(m_valid), .m_ready(m_ready), .word_cnt(word_cnt), .busy(busy)
    );

    always #5 rd_clk = ~rd_clk;

    int tests = 0;
    int fails = 0;
    int pops  = 0;

    logic [RW-1:0] fifo_q[$];
    logic [RW-1:0] pending[$];
    word_t         exp_q[$];
    word_t         got_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic word_t pack_pending();
        word_t w;
        w = '0;
        for (int i = 0; i < pending.size(); i++) begin
            w.data[i*RW +: RW] = pending[i];
            w.keep[i] = 1'b1;
        end
        return w;
    endfunction

    task automatic push(input logic [RW-1:0] d);
        fifo_q.push_back(d);
        empty = 1'b0;
    endtask

    // One clock: FIFO read port with 1-cycle latency plus the packing model.
    task automatic step();
        logic re, fl, rs;
        logic [RW-1:0] d;
        @(negedge rd_clk);
        re = rd_en; fl = flush; rs = rst_n;
        @(posedge rd_clk);
        #1;
        valid = 1'b0;
        if (re && fifo_q.size() != 0) begin
            d = fifo_q.pop_front();
            dout = d;
            valid = 1'b1;
            pops++;
            if (rs) begin
                pending.push_back(d);
                if (pending.size() == PACK) begin
                    exp_q.push_back(pack_pending());
                    pending.delete();
                end
            end
        end
        if (!rs) begin
            pending.delete();
            exp_q.delete();
        end else if (fl && pending.size() != 0) begin
            exp_q.push_back(pack_pending());
            pending.delete();
        end
        empty = (fifo_q.size() == 0);
        #1;
    endtask

    task automatic drain(input int maxc);
        int n;
        n = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0 || m_valid) && n < maxc) begin
            step();
            n++;
        end
        chk("drain_within_budget", 32'(n < maxc), 32'd1);
        repeat (3) step();
    endtask

    logic [CW-1:0]   exp_cnt = '0;
    logic            rst_seen = 1'b0;
    logic            prev_stall = 1'b0;
    logic [OW-1:0]   prev_data;
    logic [PACK-1:0] prev_keep;

    always @(negedge rd_clk) begin
        word_t w, g;
        if (!rst_n) begin
            rst_seen   = 1'b1;
            exp_cnt    = '0;
            prev_stall = 1'b0;
        end else begin
            if (rst_seen) begin
                chk("rst_m_valid", 32'(m_valid), 32'd0);
                chk("rst_m_data", 32'(m_data), 32'd0);
                chk("rst_m_keep", 32'(m_keep), 32'd0);
                chk("rst_word_cnt", 32'(word_cnt), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                rst_seen = 1'b0;
            end
            chk("rd_en_while_empty", 32'(rd_en && empty), 32'd0);
            chk("word_cnt", 32'(word_cnt), 32'(exp_cnt));
            if (prev_stall) begin
                chk("hold_valid", 32'(m_valid), 32'd1);
                chk("hold_data", 32'(m_data), 32'(prev_data));
                chk("hold_keep", 32'(m_keep), 32'(prev_keep));
            end
            if (m_valid && m_ready) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_word: got data %h keep %b, required no word", m_data, m_keep);
                end else begin
                    tests--;
                    w = exp_q.pop_front();
                    chk("word_data", 32'(m_data), 32'(w.data));
                    chk("word_keep", 32'(m_keep), 32'(w.keep));
                end
                g.data = m_data;
                g.keep = m_keep;
                got_q.push_back(g);
                exp_cnt = exp_cnt + 1'b1;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_keep  = m_keep;
        end
    end

    initial begin
        int g0, p0;
        bit hit;

        repeat (3) step();
        rst_n = 1'b1;
        step();
        chk("idle_rd_en", 32'(rd_en), 32'd0);
        chk("idle_m_valid", 32'(m_valid), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        // Four nibbles, continuous ready: latency and packing order.
        push(4'hF); push(4'h5); push(4'h6); push(4'h0);
        #1;
        chk("lat_rd_en_c0", 32'(rd_en), 32'd1);
        step();
        chk("lat_rd_en_c1", 32'(rd_en), 32'd1);
        step();
        chk("lat_m_valid_c2", 32'(m_valid), 32'd0);
        step();
        chk("lat_m_valid_c3", 32'(m_valid), 32'd1);
        chk("lat_m_data_c3", 32'(m_data), 32'h5F);
        drain(50);
        chk("t1_words", 32'(got_q.size()), 32'd2);
        chk("t1_word0", 32'(got_q[0].data), 32'h5F);
        chk("t1_word1", 32'(got_q[1].data), 32'h06);
        chk("t1_keep1", 32'(got_q[1].keep), 32'h3);
        chk("t1_word_cnt", 32'(word_cnt), 32'd2);

        // Back-pressure: credit limits pops to 2*PACK, nothing lost.
        m_ready = 1'b0;
        p0 = pops;
        for (int i = 1; i <= 8; i++) push(4'(i));
        repeat (20) step();
        chk("bp_pops", 32'(pops - p0), 32'd4);
        chk("bp_m_valid", 32'(m_valid), 32'd1);
        chk("bp_m_data", 32'(m_data), 32'h21);
        m_ready = 1'b1;
        g0 = got_q.size();
        drain(100);
        chk("bp_words", 32'(got_q.size() - g0), 32'd4);
        chk("bp_last", 32'(got_q[g0+3].data), 32'h87);

        // Single entry then flush: partial word, reads blocked while flushing.
        g0 = got_q.size();
        push(4'hA);
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        push(4'h3); push(4'hC);
        #1;
        chk("fl_rd_en_wait", 32'(rd_en), 32'd0);
        step();
        chk("fl_rd_en_emit", 32'(rd_en), 32'd0);
        chk("fl_no_word_yet", 32'(m_valid), 32'd0);
        step();
        chk("fl_m_valid", 32'(m_valid), 32'd1);
        chk("fl_m_data", 32'(m_data), 32'h0A);
        chk("fl_m_keep", 32'(m_keep), 32'h1);
        chk("fl_rd_en_run", 32'(rd_en), 32'd1);
        drain(50);
        chk("fl_words", 32'(got_q.size() - g0), 32'd2);
        chk("fl_word1", 32'(got_q[g0+1].data), 32'hC3);

        // Flush with an empty accumulator emits nothing.
        g0 = got_q.size();
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (4) step();
        chk("fle_words", 32'(got_q.size() - g0), 32'd0);
        chk("fle_busy", 32'(busy), 32'd0);

        // Flush coincident with the completing lane: one full word only.
        push(4'h7); push(4'h9);
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (5) step();
        chk("flc_words", 32'(got_q.size() - g0), 32'd1);
        chk("flc_data", 32'(got_q[g0].data), 32'h97);
        chk("flc_keep", 32'(got_q[g0].keep), 32'h3);
        chk("flc_busy", 32'(busy), 32'd0);

        // Reset while a word is held and an entry is in flight.
        m_ready = 1'b0;
        push(4'h1); push(4'h2); push(4'h3); push(4'h4);
        hit = 1'b0;
        for (int i = 0; i < 10 && !hit; i++) begin
            step();
            hit = m_valid;
        end
        chk("pre_rst_m_valid", 32'(hit), 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        m_ready = 1'b1;
        chk("post_rst_m_valid", 32'(m_valid), 32'd0);
        chk("post_rst_word_cnt", 32'(word_cnt), 32'd0);
        step();
        step();
        chk("stale_busy", 32'(busy), 32'd0);
        chk("stale_m_valid", 32'(m_valid), 32'd0);

        // 17 words with intermittent ready: counter wraps at 2^CW.
        got_q.delete();
        for (int i = 0; i < 34; i++) push(4'(i % 16));
        for (int c = 0; c < 400 && (fifo_q.size() != 0 || exp_q.size() != 0 || m_valid); c++) begin
            m_ready = (c % 3 != 2);
            step();
        end
        m_ready = 1'b1;
        drain(50);
        chk("wrap_words", 32'(got_q.size()), 32'd17);
        chk("wrap_first", 32'(got_q[0].data), 32'h10);
        chk("wrap_second", 32'(got_q[1].data), 32'h32);
        chk("wrap_word_cnt", 32'(word_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
